// File: rtl/saturating_accumulator.sv
// saturating_accumulator: streaming frame accumulator with per-step
// saturation, a sticky clip flag and a saturating sample count. A frame's
// result is held in a one-deep output register until the consumer takes it.
module saturating_accumulator #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_f_q, sat_f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] step_val;
  logic             step_clip;
  logic [CNT_W-1:0] cnt_inc;

  // Ready depends only on the output register state and the consumer.
  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_cnt   = out_cnt_q;

  // One saturating step: overflow shows as disagreement of the top two bits.
  always_comb begin
    sum       = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
    step_clip = (sum[ACC_W] != sum[ACC_W-1]);
    step_val  = sum[ACC_W-1:0];
    if (step_clip) begin
      step_val = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state, accumulator and output-register update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sat_f_d    = sat_f_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_cnt_d  = out_cnt_q;
    if (state_q == FULL && out_ready) begin
      state_d = IDLE;
    end
    if (accept) begin
      if (in_last) begin
        out_data_d = step_val;
        out_sat_d  = sat_f_q | step_clip;
        out_cnt_d  = cnt_inc;
        state_d    = FULL;
        acc_d      = '0;
        sat_f_d    = 1'b0;
        cnt_d      = '0;
      end else begin
        acc_d   = step_val;
        sat_f_d = sat_f_q | step_clip;
        cnt_d   = cnt_inc;
      end
    end
  end

  // State registers; reset discards any partial frame and pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      sat_f_q    <= 1'b0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      sat_f_q    <= sat_f_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_cnt_q  <= out_cnt_d;
    end
  end

endmodule

// File: tb/tb_saturating_accumulator.sv
// Scoreboard bench for saturating_accumulator: the driver pushes expected
// frame results, the monitor pops and compares on each output transfer.
module tb_saturating_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_data;
  logic       out_sat;
  logic [7:0] out_cnt;

  typedef struct {
    int d;
    int s;
    int c;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  saturating_accumulator #(.IN_W(4), .ACC_W(6), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_cnt   (out_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: a result transfers on the coming edge when valid and ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got data=%0d with empty scoreboard", $signed(out_data));
      end else begin
        e = exp_q.pop_front();
        chk("result_data", int'($signed(out_data)), e.d);
        chk("result_sat", int'(out_sat), e.s);
        chk("result_cnt", int'(out_cnt), e.c);
      end
    end
  end

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input int d, input bit last);
    int waited;
    logic [31:0] dv;
    dv       = d;
    in_valid = 1'b1;
    in_data  = dv[3:0];
    in_last  = last;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      waited++;
      if (waited > 20) begin
        total++;
        bad++;
        $display("FAIL send_timeout: beat %0d not accepted after %0d cycles", d, waited);
        break;
      end
    end
  endtask

  task automatic idle_beat();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input int d, input int s, input int c);
    exp_t e;
    e.d = d;
    e.s = s;
    e.c = c;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("reset_imm_valid", int'(out_valid), 0);
    chk("reset_imm_ready", int'(in_ready), 1);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 4'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_data", int'(out_data), 0);
      chk("reset_cnt", int'(out_cnt), 0);
      chk("reset_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
    end
    idle_beat();
    out_ready = 1'b1;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // Positive saturation.
    push(31, 1, 5);
    for (int i = 0; i < 5; i++) send(7, i == 4);
    // Recovery after saturation, back to back with the previous frame.
    push(23, 1, 6);
    for (int i = 0; i < 5; i++) send(7, 0);
    send(-8, 1);
    // Negative saturation.
    push(-32, 1, 5);
    for (int i = 0; i < 5; i++) send(-8, i == 4);
    // No saturation.
    push(5, 0, 4);
    send(3, 0);
    send(-2, 0);
    send(5, 0);
    send(-1, 1);
    idle_beat();
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held, sample presented but refused.
    out_ready = 1'b0;
    push(1, 0, 1);
    send(1, 1);
    in_valid = 1'b1;
    in_data  = 4'd5;
    in_last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'($signed(out_data)), 1);
      chk("bp_cnt", int'(out_cnt), 1);
    end
    @(posedge clk);
    #1;
    // Same-cycle handoff of the held result and load of the next frame.
    out_ready = 1'b1;
    push(2, 0, 1);
    send(2, 1);
    chk("overlap_valid", int'(out_valid), 1);
    chk("overlap_data", int'($signed(out_data)), 2);
    idle_beat();
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame with a pending result: both are discarded.
    send(6, 0);
    send(6, 0);
    out_ready = 1'b0;
    send(4, 1);
    idle_beat();
    chk("pending_before_rst", int'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_assert_valid", int'(out_valid), 0);
    chk("rst_assert_data", int'(out_data), 0);
    chk("rst_assert_cnt", int'(out_cnt), 0);
    chk("rst_assert_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    push(1, 0, 1);
    send(1, 1);
    idle_beat();

    // Drain the scoreboard.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
